// File: rtl/exec_pkg.sv
// Shared definitions for the execution/writeback result queue:
// integer op encodings, FPU flag layout and the queue entry layout.
package exec_pkg;

  localparam int FLAGW   = 5;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_LI   = 3'b101,
    OP_SLT  = 3'b110,
    OP_SLTU = 3'b111
  } int_op_e;

  // Entry layout at the default widths (XLEN=32, TAGW=5); the top builds
  // its own equivalent struct from its parameters.
  typedef struct packed {
    logic [31:0]      data;
    logic [4:0]       rd;
    logic             is_fp;
    logic [FLAGW-1:0] flags;
  } exec_entry_t;

endpackage

// File: rtl/exec_result_fifo.sv
// DEPTH-entry result queue with two push ports (A is older than B when both
// fire) and a single pop port. DEPTH need not be a power of two.
module exec_result_fifo
  import exec_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = exec_entry_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push_a,
  input  T              i_data_a,
  input  logic          i_push_b,
  input  T              i_data_b,
  input  logic          i_pop,
  output T              o_head,
  output logic [CW-1:0] o_count
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wr_ptr_b;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Slot for port B sits behind port A's slot when both push.
  always_comb begin
    w_wr_ptr_b   = i_push_a ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_wr_ptr_nxt = i_push_b ? ptr_inc(w_wr_ptr_b) : w_wr_ptr_b;
    w_count_nxt  = r_count + CW'(i_push_a) + CW'(i_push_b) - CW'(i_pop);
  end

  // Storage, pointers and occupancy; reset clears the array so the head reads zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push_a) r_mem[r_wr_ptr]   <= i_data_a;
      if (i_push_b) r_mem[w_wr_ptr_b] <= i_data_b;
      if (i_pop)    r_rd_ptr          <= ptr_inc(r_rd_ptr);
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/exec_result_queue.sv
// Execution/writeback stage: single-cycle integer ALU merged with FPU
// completions into one in-order writeback stream with valid/ready.
// Optional feature macro: EXEC_OVF_FLAG_EN (signed-overflow OF flag on
// integer ADD/SUB results).
module exec_result_queue
  import exec_pkg::*;
#(
  parameter int  XLEN  = 32,
  parameter int  DEPTH = 4,
  parameter int  TAGW  = 5,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_int_valid,
  output logic             o_int_ready,
  input  logic [2:0]       i_int_op,
  input  logic [XLEN-1:0]  i_int_rs1,
  input  logic [XLEN-1:0]  i_int_rs2,
  input  logic [TAGW-1:0]  i_int_rd,
  input  logic             i_fpu_complete,
  input  logic [XLEN-1:0]  i_fpu_result,
  input  logic [TAGW-1:0]  i_fpu_rd,
  input  logic [FLAGW-1:0] i_fpu_flags,
  output logic             o_wb_valid,
  input  logic             i_wb_ready,
  output logic [XLEN-1:0]  o_wb_data,
  output logic [TAGW-1:0]  o_wb_rd,
  output logic             o_wb_is_fp,
  output logic [FLAGW-1:0] o_wb_flags,
  output logic [CW-1:0]    o_count,
  output logic             o_ovf_err
);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAGW-1:0]  rd;
    logic             is_fp;
    logic [FLAGW-1:0] flags;
  } entry_t;

  logic [XLEN-1:0]  w_sum;
  logic [XLEN-1:0]  w_diff;
  logic [XLEN-1:0]  w_alu;
  logic [FLAGW-1:0] w_int_flags;
  logic [CW-1:0]    w_count;
  logic             w_int_ready;
  logic             w_int_accept;
  logic             w_fpu_accept;
  logic             w_wb_valid;
  logic             w_pop;
  entry_t           w_fpu_entry;
  entry_t           w_int_entry;
  entry_t           w_head;
  logic             r_ovf_err;

  // Integer ALU; arithmetic wraps modulo 2^XLEN, compares yield 0/1.
  always_comb begin
    w_sum  = i_int_rs1 + i_int_rs2;
    w_diff = i_int_rs1 - i_int_rs2;
    w_alu  = '0;
    case (i_int_op)
      OP_ADD:  w_alu = w_sum;
      OP_SUB:  w_alu = w_diff;
      OP_AND:  w_alu = i_int_rs1 & i_int_rs2;
      OP_OR:   w_alu = i_int_rs1 | i_int_rs2;
      OP_XOR:  w_alu = i_int_rs1 ^ i_int_rs2;
      OP_LI:   w_alu = i_int_rs2;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(i_int_rs1) < $signed(i_int_rs2))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (i_int_rs1 < i_int_rs2)};
      default: w_alu = '0;
    endcase
  end

`ifdef EXEC_OVF_FLAG_EN
  // Signed overflow: operands' signs make overflow possible and result sign differs from rs1.
  always_comb begin
    w_int_flags = '0;
    if (i_int_op == OP_ADD)
      w_int_flags[FLAG_OF] = (i_int_rs1[XLEN-1] == i_int_rs2[XLEN-1]) &&
                             (w_sum[XLEN-1] != i_int_rs1[XLEN-1]);
    else if (i_int_op == OP_SUB)
      w_int_flags[FLAG_OF] = (i_int_rs1[XLEN-1] != i_int_rs2[XLEN-1]) &&
                             (w_diff[XLEN-1] != i_int_rs1[XLEN-1]);
  end
`else
  assign w_int_flags = '0;
`endif

  // Integer traffic always leaves one slot free so an FPU completion never has to stall.
  always_comb begin
    w_wb_valid   = (w_count != '0);
    w_pop        = w_wb_valid & i_wb_ready;
    w_int_ready  = (w_count <= CW'(DEPTH - 2));
    w_int_accept = i_int_valid & w_int_ready;
    w_fpu_accept = i_fpu_complete & ((w_count < CW'(DEPTH)) | w_pop);
    w_fpu_entry  = '{data: i_fpu_result, rd: i_fpu_rd, is_fp: 1'b1, flags: i_fpu_flags};
    w_int_entry  = '{data: w_alu, rd: i_int_rd, is_fp: 1'b0, flags: w_int_flags};
  end

  exec_result_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push_a (w_fpu_accept),
    .i_data_a (w_fpu_entry),
    .i_push_b (w_int_accept),
    .i_data_b (w_int_entry),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_count  (w_count)
  );

  // Sticky record of an FPU completion lost to a full queue.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_ovf_err <= 1'b0;
    else if (i_fpu_complete && !w_fpu_accept)
      r_ovf_err <= 1'b1;
  end

  assign o_int_ready = w_int_ready;
  assign o_wb_valid  = w_wb_valid;
  assign o_wb_data   = w_head.data;
  assign o_wb_rd     = w_head.rd;
  assign o_wb_is_fp  = w_head.is_fp;
  assign o_wb_flags  = w_head.flags;
  assign o_count     = w_count;
  assign o_ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_exec_result_queue.sv
// Scoreboard bench for exec_result_queue (XLEN=32, DEPTH=4, TAGW=5).
module tb_exec_result_queue;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        is_fp;
    logic [4:0]  flags;
  } exp_t;

`ifdef EXEC_OVF_FLAG_EN
  localparam logic [4:0] OFX = 5'b00100;
`else
  localparam logic [4:0] OFX = 5'b00000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        int_valid = 1'b0;
  logic        int_ready;
  logic [2:0]  int_op = '0;
  logic [31:0] int_rs1 = '0;
  logic [31:0] int_rs2 = '0;
  logic [4:0]  int_rd = '0;
  logic        fpu_complete = 1'b0;
  logic [31:0] fpu_result = '0;
  logic [4:0]  fpu_rd = '0;
  logic [4:0]  fpu_flags = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_is_fp;
  logic [4:0]  wb_flags;
  logic [2:0]  count;
  logic        ovf_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  exec_result_queue #(.XLEN(32), .DEPTH(4), .TAGW(5)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_int_valid    (int_valid),
    .o_int_ready    (int_ready),
    .i_int_op       (int_op),
    .i_int_rs1      (int_rs1),
    .i_int_rs2      (int_rs2),
    .i_int_rd       (int_rd),
    .i_fpu_complete (fpu_complete),
    .i_fpu_result   (fpu_result),
    .i_fpu_rd       (fpu_rd),
    .i_fpu_flags    (fpu_flags),
    .o_wb_valid     (wb_valid),
    .i_wb_ready     (wb_ready),
    .o_wb_data      (wb_data),
    .o_wb_rd        (wb_rd),
    .o_wb_is_fp     (wb_is_fp),
    .o_wb_flags     (wb_flags),
    .o_count        (count),
    .o_ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid & ready here.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got data 0x%0h rd %0d, expected no entry", wb_data, wb_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_data",  64'(wb_data),  64'(e.data));
        check("wb_rd",    64'(wb_rd),    64'(e.rd));
        check("wb_is_fp", 64'(wb_is_fp), 64'(e.is_fp));
        check("wb_flags", 64'(wb_flags), 64'(e.flags));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_int(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    int_valid = 1'b1; int_op = op; int_rs1 = a; int_rs2 = b; int_rd = rd;
  endtask

  task automatic set_fpu(input logic [31:0] res, input logic [4:0] rd, input logic [4:0] fl);
    fpu_complete = 1'b1; fpu_result = res; fpu_rd = rd; fpu_flags = fl;
  endtask

  task automatic clr_in();
    int_valid = 1'b0;
    fpu_complete = 1'b0;
  endtask

  task automatic expect_entry(input logic [31:0] d, input logic [4:0] rd, input logic fp,
                              input logic [4:0] fl);
    exp_t e;
    e.data = d; e.rd = rd; e.is_fp = fp; e.flags = fl;
    exp_q.push_back(e);
  endtask

  // Issue one integer op that is expected to be accepted.
  task automatic do_int(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input logic [4:0] fl);
    set_int(op, a, b, rd);
    expect_entry(res, rd, 1'b0, fl);
    tick();
    clr_in();
  endtask

  task automatic drain(input string name);
    int n;
    wb_ready = 1'b1;
    n = 0;
    while ((count != 0 || exp_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(count == 0 && exp_q.size() == 0), 64'd1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_count",    64'(count),     64'd0);
    check("rst_wb_valid", 64'(wb_valid),  64'd0);
    check("rst_ovf",      64'(ovf_err),   64'd0);
    check("rst_int_rdy",  64'(int_ready), 64'd1);
    check("rst_wb_data",  64'(wb_data),   64'd0);
    check("rst_wb_rd",    64'(wb_rd),     64'd0);
    check("rst_wb_flags", 64'(wb_flags),  64'd0);
    check("rst_wb_is_fp", 64'(wb_is_fp),  64'd0);

    // 1: ADD wrapping to zero, one-cycle latency
    wb_ready = 1'b1;
    do_int(3'b000, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0, 5'b0);
    check("t1_latency_valid", 64'(wb_valid), 64'd1);
    check("t1_count", 64'(count), 64'd1);
    drain("t1_drain");

    // 2: simultaneous FPU + int, FPU is older
    set_fpu(32'h3F80_0000, 5'd7, 5'b00001);
    set_int(3'b100, 32'h0000_F0F0, 32'h0000_0FF0, 5'd2);
    expect_entry(32'h3F80_0000, 5'd7, 1'b1, 5'b00001);
    expect_entry(32'h0000_FF00, 5'd2, 1'b0, 5'b0);
    tick();
    clr_in();
    check("t2_count", 64'(count), 64'd2);
    drain("t2_drain");

    // 5 plus assorted ALU ops back-to-back
    do_int(3'b000, 32'h7FFF_FFFF, 32'h1, 5'd9,  32'h8000_0000, OFX);
    do_int(3'b001, 32'h8000_0000, 32'h1, 5'd10, 32'h7FFF_FFFF, OFX);
    do_int(3'b001, 32'd5, 32'd7, 5'd6,  32'hFFFF_FFFE, 5'b0);
    do_int(3'b111, 32'h1, 32'hFFFF_FFFF, 5'd12, 32'h1, 5'b0);
    do_int(3'b111, 32'hFFFF_FFFF, 32'h1, 5'd15, 32'h0, 5'b0);
    do_int(3'b010, 32'h0000_FF0F, 32'h0000_0FF0, 5'd11, 32'h0000_0F00, 5'b0);
    drain("t5_drain");

    // 3: stall writeback, fill with ints until int_ready drops
    wb_ready = 1'b0;
    check("t3_rdy0", 64'(int_ready), 64'd1);
    do_int(3'b011, 32'h0000_00FF, 32'h0000_FF00, 5'd4, 32'h0000_FFFF, 5'b0);
    check("t3_rdy1", 64'(int_ready), 64'd1);
    do_int(3'b101, 32'hDEAD_0000, 32'h0000_1234, 5'd5, 32'h0000_1234, 5'b0);
    check("t3_rdy2", 64'(int_ready), 64'd1);
    do_int(3'b001, 32'd5, 32'd7, 5'd6, 32'hFFFF_FFFE, 5'b0);
    check("t3_count3", 64'(count), 64'd3);
    check("t3_rdy3", 64'(int_ready), 64'd0);
    set_int(3'b000, 32'h1, 32'h1, 5'd1);
    tick();
    clr_in();
    check("t3_int_refused", 64'(count), 64'd3);
    check("t3_hold_data", 64'(wb_data), 64'h0000_FFFF);
    set_fpu(32'h4000_0000, 5'd8, 5'b0);
    expect_entry(32'h4000_0000, 5'd8, 1'b1, 5'b0);
    tick();
    clr_in();
    check("t3_count4", 64'(count), 64'd4);
    check("t3_ovf0", 64'(ovf_err), 64'd0);

    // 4: full, pop and FPU push in the same cycle
    wb_ready = 1'b1;
    set_fpu(32'h4040_0000, 5'd9, 5'b10000);
    expect_entry(32'h4040_0000, 5'd9, 1'b1, 5'b10000);
    tick();
    clr_in();
    wb_ready = 1'b0;
    check("t4_count4", 64'(count), 64'd4);
    check("t4_ovf0", 64'(ovf_err), 64'd0);
    check("t4_head", 64'(wb_data), 64'h0000_1234);

    // 3 cont.: FPU into a full, stalled queue is dropped
    set_fpu(32'hDEAD_BEEF, 5'd10, 5'b0);
    tick();
    clr_in();
    check("t3_drop_count", 64'(count), 64'd4);
    check("t3_ovf1", 64'(ovf_err), 64'd1);
    tick();
    check("t3_ovf_sticky", 64'(ovf_err), 64'd1);
    drain("t3_drain");

    // 6: reset with three entries pending; reset-cycle inputs ignored
    wb_ready = 1'b0;
    do_int(3'b000, 32'd2, 32'd3, 5'd13, 32'd5, 5'b0);
    do_int(3'b000, 32'd4, 32'd3, 5'd14, 32'd7, 5'b0);
    do_int(3'b000, 32'd6, 32'd3, 5'd15, 32'd9, 5'b0);
    check("t6_count3", 64'(count), 64'd3);
    rst = 1'b1;
    exp_q.delete();
    set_int(3'b000, 32'd1, 32'd1, 5'd1);
    set_fpu(32'h1111_1111, 5'd2, 5'b0);
    tick();
    rst = 1'b0;
    clr_in();
    check("t6_count0", 64'(count), 64'd0);
    check("t6_valid0", 64'(wb_valid), 64'd0);
    check("t6_ovf0", 64'(ovf_err), 64'd0);
    wb_ready = 1'b1;
    do_int(3'b110, 32'hFFFF_FFFF, 32'h1, 5'd14, 32'h1, 5'b0);
    check("t6_slt_valid", 64'(wb_valid), 64'd1);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
